pipe_stage_skid_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the ARM core (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

---
 rtl/pipe_stage_skid_reg_pkg.sv | 51 +++++
 rtl/pipe_stage_skid_reg_entry.sv | 25 ++
 rtl/pipe_stage_skid_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: the default ID/EXE field layout
// and the occupancy state encoding.
package pipe_stage_skid_reg_pkg;

    localparam int unsigned CTRL_W_DEF   = 8;
    localparam int unsigned DATA_W_DEF   = 128;

    // Control field layout (LSB first)
    localparam int unsigned WB_EN_BIT    = 0;
    localparam int unsigned MEM_R_EN_BIT = 1;
    localparam int unsigned MEM_W_EN_BIT = 2;
    localparam int unsigned EXE_CMD_LSB  = 3;
    localparam int unsigned EXE_CMD_W    = 3;
    localparam int unsigned B_BIT        = 6;
    localparam int unsigned S_BIT        = 7;

    // Payload field layout (LSB first)
    localparam int unsigned PC_LSB       = 0;
    localparam int unsigned PC_W         = 32;
    localparam int unsigned VAL1_LSB     = 32;
    localparam int unsigned VAL1_W       = 32;
    localparam int unsigned VALRM_LSB    = 64;
    localparam int unsigned VALRM_W      = 32;
    localparam int unsigned IMM_BIT      = 96;
    localparam int unsigned SHIFT_LSB    = 97;
    localparam int unsigned SHIFT_W      = 12;
    localparam int unsigned SIMM_LSB     = 109;
    localparam int unsigned SIMM_W       = 14;
    localparam int unsigned DEST_LSB     = 123;
    localparam int unsigned DEST_W       = 4;
    localparam int unsigned C_BIT        = 127;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    function automatic stage_state_e state_of(input logic main_v, input logic skid_v);
        stage_state_e st;
        if (skid_v) begin
            st = ST_TWO;
        end else if (main_v) begin
            st = ST_ONE;
        end else begin
            st = ST_EMPTY;
        end
        return st;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_entry.sv
// One pipeline entry (valid + control + payload) held in a load-enabled register.
module stage_entry_reg #(
    parameter int unsigned W = 137
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] entry_q;

    // Entry storage: cleared asynchronously, loaded only when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= {W{1'b0}};
        end else if (en_i) begin
            entry_q <= d_i;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, freeze, flush, bubble masking of
// control fields and an optional second (skid) entry that lets in_ready come from a flop.
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int unsigned ENT_W = CTRL_W + DATA_W + 1;

    typedef struct packed {
        logic              v;
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } entry_t;

    entry_t       main_q;
    entry_t       skid_q;
    entry_t       main_d;
    entry_t       skid_d;
    entry_t       in_ent_s;
    logic         main_en_s;
    logic         skid_en_s;
    logic         accept_s;
    logic         drain_s;
    logic         skid_v_s;
    stage_state_e state_s;

    stage_entry_reg #(.W(ENT_W)) u_main (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (main_en_s),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    generate
        if (SKID) begin : g_skid
            stage_entry_reg #(.W(ENT_W)) u_skid (
                .clk   (clk),
                .rst_n (rst),
                .en_i  (skid_en_s),
                .d_i   (skid_d),
                .q_o   (skid_q)
            );
            assign in_ready = ~skid_q.v & ~freeze;
        end else begin : g_noskid
            assign skid_q   = {ENT_W{1'b0}};
            assign in_ready = (~main_q.v | out_ready) & ~freeze;
        end
    endgenerate

    assign skid_v_s = skid_q.v;
    assign state_s  = state_of(main_q.v, skid_v_s);
    assign in_ent_s = {1'b1, in_ctrl, in_data};
    assign accept_s = in_valid & in_ready & ~freeze & ~flush;
    assign drain_s  = main_q.v & out_ready;

    // Next-entry selection; flush wins over every other transfer in the cycle
    always_comb begin
        main_en_s = 1'b0;
        skid_en_s = 1'b0;
        main_d    = main_q;
        skid_d    = skid_q;
        if (flush) begin
            main_en_s = 1'b1;
            skid_en_s = 1'b1;
            main_d    = {ENT_W{1'b0}};
            skid_d    = {ENT_W{1'b0}};
        end else begin
            case (state_s)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_en_s = 1'b1;
                        main_d    = in_ent_s;
                    end else begin
                        main_en_s = 1'b0;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        main_en_s = 1'b1;
                        main_d    = in_ent_s;
                    end else if (accept_s) begin
                        skid_en_s = 1'b1;
                        skid_d    = in_ent_s;
                    end else if (drain_s) begin
                        main_en_s = 1'b1;
                        main_d.v  = 1'b0;
                    end else begin
                        main_en_s = 1'b0;
                    end
                end
                ST_TWO: begin
                    if (drain_s) begin
                        main_en_s = 1'b1;
                        skid_en_s = 1'b1;
                        main_d    = skid_q;
                        skid_d.v  = 1'b0;
                    end else begin
                        main_en_s = 1'b0;
                    end
                end
                default: begin
                    main_en_s = 1'b1;
                    skid_en_s = 1'b1;
                    main_d    = {ENT_W{1'b0}};
                    skid_d    = {ENT_W{1'b0}};
                end
            endcase
        end
    end

    // Control bits are masked so a bubble can never carry a write enable downstream
    assign out_valid = main_q.v;
    assign out_ctrl  = main_q.c & {CTRL_W{main_q.v}};
    assign out_data  = main_q.d;
    assign occupancy = {1'b0, main_q.v} + {1'b0, skid_v_s};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: SKID=0 and SKID=1 instances share stimulus, each checked
// every cycle against a queue model; a directed table also pins the SKID=1 instance.
module tb_pipe_stage_skid_reg;

    localparam int CW = 8;
    localparam int DW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          freeze;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic [1:0]          irdy;
    logic [1:0]          ov;
    logic [1:0][CW-1:0]  octrl;
    logic [1:0][DW-1:0]  odat;
    logic [1:0][1:0]     occ;

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_dut_s0 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(irdy[0]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(octrl[0]), .out_data(odat[0]),
        .occupancy(occ[0])
    );

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_dut_s1 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(irdy[1]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(octrl[1]), .out_data(odat[1]),
        .occupancy(occ[1])
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic        fz;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [7:0]  c;
        logic [31:0] dn;
        logic        e_irdy;
        logic        e_ov;
        logic [1:0]  e_occ;
        logic [7:0]  e_ctrl;
        logic [31:0] e_dn;
    } vec_t;

    ent_t q0[$];
    ent_t q1[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_irdy(input int i, input int sz);
        if (i == 1) return (sz < 2) && !freeze;
        return ((sz == 0) || out_ready) && !freeze;
    endfunction

    task automatic check_model(input int i);
        ent_t q[$];
        if (i == 1) q = q1; else q = q0;
        chk($sformatf("inst%0d in_ready", i), {127'd0, irdy[i]}, {127'd0, exp_irdy(i, q.size())});
        chk($sformatf("inst%0d out_valid", i), {127'd0, ov[i]}, {127'd0, q.size() > 0});
        chk($sformatf("inst%0d occupancy", i), {126'd0, occ[i]}, 128'(q.size()));
        chk($sformatf("inst%0d out_ctrl", i), {120'd0, octrl[i]},
            {120'd0, (q.size() > 0) ? q[0].c : 8'h00});
        if (q.size() > 0) chk($sformatf("inst%0d out_data", i), odat[i], q[0].d);
    endtask

    task automatic update_model(input int i);
        ent_t q[$];
        logic rdy;
        logic drn;
        if (i == 1) q = q1; else q = q0;
        rdy = exp_irdy(i, q.size());
        if (!rst || flush) begin
            q.delete();
        end else begin
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (in_valid && rdy) q.push_back({in_ctrl, in_data});
        end
        if (i == 1) q1 = q; else q0 = q;
    endtask

    task automatic apply(input logic r, input logic fz, input logic fl, input logic iv,
                         input logic ordy, input logic [CW-1:0] c, input logic [DW-1:0] d);
        @(negedge clk);
        rst = r; freeze = fz; flush = fl; in_valid = iv; out_ready = ordy;
        in_ctrl = c; in_data = d;
        #1;
        if (!rst) begin
            q0.delete();
            q1.delete();
        end
        check_model(0);
        check_model(1);
    endtask

    task automatic advance();
        @(posedge clk);
        update_model(0);
        update_model(1);
    endtask

    vec_t vecs[14];

    initial begin
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_ctrl = 8'hFF; in_data = {DW{1'b1}};

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 32'd1, 1'b1, 1'b0, 2'd0, 8'h00, 32'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 32'd2, 1'b1, 1'b1, 2'd1, 8'h11, 32'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h13, 32'd3, 1'b0, 1'b1, 2'd2, 8'h11, 32'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h13, 32'd3, 1'b0, 1'b1, 2'd2, 8'h11, 32'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h13, 32'd3, 1'b1, 1'b1, 2'd1, 8'h12, 32'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'd0, 1'b1, 1'b1, 2'd1, 8'h13, 32'd3};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 2'd0, 8'h00, 32'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h14, 32'd4, 1'b1, 1'b0, 2'd0, 8'h00, 32'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h15, 32'd5, 1'b0, 1'b1, 2'd1, 8'h14, 32'd4};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h15, 32'd5, 1'b0, 1'b0, 2'd0, 8'h00, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h15, 32'd5, 1'b1, 1'b0, 2'd0, 8'h00, 32'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h16, 32'd6, 1'b1, 1'b1, 2'd1, 8'h15, 32'd5};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h17, 32'd7, 1'b0, 1'b1, 2'd2, 8'h15, 32'd5};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'd0, 1'b1, 1'b0, 2'd0, 8'h00, 32'd0};

        // Reset held with an incoming entry present
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, {DW{1'b1}});
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset inst%0d out_valid", i), {127'd0, ov[i]}, 128'd0);
            chk($sformatf("reset inst%0d in_ready", i), {127'd0, irdy[i]}, 128'd1);
        end
        advance();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, {DW{1'b0}});
        advance();

        // Directed backpressure / freeze / flush sequence
        for (int k = 0; k < 14; k++) begin
            apply(1'b1, vecs[k].fz, vecs[k].fl, vecs[k].iv, vecs[k].ordy, vecs[k].c,
                  {96'd0, vecs[k].dn});
            chk($sformatf("vec%0d in_ready", k), {127'd0, irdy[1]}, {127'd0, vecs[k].e_irdy});
            chk($sformatf("vec%0d out_valid", k), {127'd0, ov[1]}, {127'd0, vecs[k].e_ov});
            chk($sformatf("vec%0d occupancy", k), {126'd0, occ[1]}, {126'd0, vecs[k].e_occ});
            chk($sformatf("vec%0d out_ctrl", k), {120'd0, octrl[1]}, {120'd0, vecs[k].e_ctrl});
            if (vecs[k].e_ov) chk($sformatf("vec%0d out_data", k), odat[1], {96'd0, vecs[k].e_dn});
            advance();
        end

        // Back-to-back streaming with downstream always ready
        for (int n = 1; n <= 10; n++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, DW'(n));
            advance();
        end
        for (int n = 0; n < 3; n++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, {DW{1'b0}});
            advance();
        end

        // Random traffic, including one reset pulse mid-stream
        for (int k = 0; k < 400; k++) begin
            apply((k != 200) ? 1'b1 : 1'b0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)),
                  8'($urandom),
                  {$urandom, $urandom, $urandom, $urandom});
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
